// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: sequences start, serializer data, optional parity
// and stop bits onto the TX line, and gates the external serializer.
module uart_tx_frame_ctrl #(
    parameter int DATA_LENGTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_LENGTH-1:0] P_DATA,
    input  logic                   Data_valid,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic                   ser_data,
    input  logic                   ser_done,
    output logic                   ser_en,
    output logic                   TX_OUT,
    output logic                   busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   par_bit_r;
    logic   par_en_r;
    logic   accept_s;

    // Even parity is the XOR of all bits; odd parity is its complement.
    function automatic logic parity_calc(input logic [DATA_LENGTH-1:0] data,
                                         input logic                   odd);
        parity_calc = (^data) ^ odd;
    endfunction

    // A request is taken only from IDLE or on the STOP exit edge.
    always_comb begin
        accept_s = 1'b0;
        if (Data_valid && ((state_r == IDLE) || (state_r == STOP))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Next-state decode; an unreachable encoding falls back to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                state_next_s = DATA;
            end
            DATA: begin
                if (ser_done) begin
                    if (par_en_r) begin
                        state_next_s = PARITY;
                    end else begin
                        state_next_s = STOP;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                state_next_s = STOP;
            end
            STOP: begin
                if (accept_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Per-frame configuration captured at acceptance so mid-frame input changes are inert.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_bit_r <= 1'b0;
            par_en_r  <= 1'b0;
        end else if (accept_s) begin
            par_bit_r <= parity_calc(P_DATA, PAR_TYP);
            par_en_r  <= PAR_EN;
        end
    end

    // Line, enable and busy decode straight from state so reset forces them at once.
    always_comb begin
        TX_OUT = 1'b1;
        ser_en = 1'b0;
        busy   = 1'b0;
        case (state_r)
            IDLE: begin
                TX_OUT = 1'b1;
                ser_en = 1'b0;
                busy   = 1'b0;
            end
            START: begin
                TX_OUT = 1'b0;
                ser_en = 1'b0;
                busy   = 1'b1;
            end
            DATA: begin
                TX_OUT = ser_data;
                ser_en = 1'b1;
                busy   = 1'b1;
            end
            PARITY: begin
                TX_OUT = par_bit_r;
                ser_en = 1'b0;
                busy   = 1'b1;
            end
            STOP: begin
                TX_OUT = 1'b1;
                ser_en = 1'b0;
                busy   = 1'b1;
            end
            default: begin
                TX_OUT = 1'b1;
                ser_en = 1'b0;
                busy   = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
Frame controller for the UART transmitter. It accepts a parallel byte, sequences the start bit, the serializer-driven data bits, an optional parity bit and the stop bit onto the line, and drives the serializer's enable. It sits directly downstream of the serializer, consumes its ser_data and ser_done outputs, and owns the TX pin. One CLK cycle is one bit period; the baud-rate clock is generated outside this block.

Parameters:
DATA_LENGTH, 8, width of P_DATA and number of data bits per frame.

Ports:
CLK  input  1  bit-rate clock; all flops rising-edge.
RST  input  1  asynchronous, active-high reset.
P_DATA  input  DATA_LENGTH  byte to send; used only for parity, sampled on acceptance.
Data_valid  input  1  request to send P_DATA; single-cycle or level.
PAR_EN  input  1  parity enable, sampled on acceptance.
PAR_TYP  input  1  0 = even parity, 1 = odd parity, sampled on acceptance.
ser_data  input  1  current data bit from the serializer.
ser_done  input  1  serializer reports that the last data bit is in progress.
ser_en  output  1  serializer shift enable.
TX_OUT  output  1  UART line; idle high.
busy  output  1  frame in progress; new requests are ignored while high.

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. The state register is clocked; outputs decode combinationally from state.
- Reset (async, RST=1): state=IDLE and the latched parity/config flops cleared. The outputs are then TX_OUT=1, ser_en=0, busy=0. A reset in the middle of a frame aborts the frame and returns TX_OUT to 1 immediately. No partial frame resumes after reset release.
- IDLE: TX_OUT=1, busy=0. A request is accepted when Data_valid=1 at a CLK edge. On that edge the block latches:
  - par_bit = ^P_DATA for even parity, ~^P_DATA for odd parity;
  - PAR_EN.
  - It then moves to START.
- START: TX_OUT=0, busy=1, ser_en=0, for exactly one cycle, then DATA.
- DATA: ser_en=1, TX_OUT=ser_data, busy=1.
  - The serializer must present each bit combinationally valid during the cycle it is transmitted.
  - The state remains DATA until ser_done=1 is sampled at an edge.
  - It then moves to PARITY if the latched PAR_EN=1, otherwise to STOP.
  - With a compliant serializer, DATA lasts exactly DATA_LENGTH cycles. No timeout: a missing ser_done holds DATA indefinitely.
- PARITY: TX_OUT=par_bit, ser_en=0, busy=1, one cycle, then STOP.
- STOP: TX_OUT=1, ser_en=0, busy=1, one cycle.
  - If Data_valid=1 at the exiting edge, the new request is accepted (parity/config latched) and the next state is START. This gives back-to-back frames with no idle gap.
  - Otherwise the next state is IDLE.
- Data_valid in START, DATA or PARITY is ignored, with no queuing. The caller must re-assert it.
- P_DATA, PAR_EN and PAR_TYP changing mid-frame have no effect on the current frame.
- Frame length is 1 + DATA_LENGTH + PAR_EN + 1 cycles: 11 with parity and 10 without at the default.
- Latency: the first start-bit cycle begins on the edge that accepts Data_valid. TX_OUT goes low in the cycle after that edge.
- ser_done seen outside DATA is ignored.

Test Plan:
- Reset, then idle for 5 cycles -> TX_OUT=1, busy=0 and ser_en=0 throughout. Asserting RST between clock edges forces these values asynchronously.
- P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, with a behavioural serializer (LSB first) -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1. busy is high for 11 cycles and ser_en is high for exactly 8.
- P_DATA=8'hA5, PAR_EN=1, PAR_TYP=1 -> parity cycle carries 1. P_DATA=8'h3C, PAR_EN=0 -> 0,0,0,1,1,1,1,0,0,1 over 10 cycles, with no parity state.
- Data_valid held high across two frames (8'h01 then 8'hFF, parity off) -> STOP is followed directly by START. The result is 20 consecutive busy cycles and the line never stays high for two cycles between frames.
- Data_valid pulsed during DATA with a different P_DATA and PAR_TYP toggled -> the current frame is bit-exact to the original request, the pulse is not transmitted, and busy drops after STOP.
- RST asserted in the 3rd data bit -> TX_OUT=1, ser_en=0 and busy=0 immediately. After release with Data_valid low, the block stays IDLE and no further bits appear.
